// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: tracks in-flight destination registers, picks forward sources and raises load-use stalls
module hazard_forward_unit #(
   parameter int REG_NUM_WIDTH = 5,
   parameter int NUM_READ      = 2,
   parameter int DEPTH         = 2,
   parameter int FLUSH_DEPTH   = 1,
   parameter int SEL_WIDTH     = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              hold,
   input  logic                              flush,
   input  logic                              id_valid,
   input  logic [NUM_READ*REG_NUM_WIDTH-1:0] rd_num,
   input  logic [NUM_READ-1:0]               rd_used,
   input  logic [REG_NUM_WIDTH-1:0]          wr_num,
   input  logic                              wr_en,
   input  logic                              wr_is_load,
   output logic [NUM_READ*SEL_WIDTH-1:0]     fwd_sel,
   output logic                              load_use_stall,
   output logic [31:0]                       stall_count
);
   logic [DEPTH:1]            v;
   logic [DEPTH:1]            ld;
   logic [REG_NUM_WIDTH-1:0]  num [1:DEPTH];
   logic [NUM_READ*SEL_WIDTH-1:0] raw_sel;
   logic                      stall_c;

   function automatic logic hit(input int i, input int k);
      return rd_used[i] && (rd_num[i*REG_NUM_WIDTH +: REG_NUM_WIDTH] != '0) && v[k] &&
             (num[k] == rd_num[i*REG_NUM_WIDTH +: REG_NUM_WIDTH]);
   endfunction

   // scanning oldest to youngest lets the youngest producer overwrite the select
   always_comb begin
      raw_sel = '0;
      stall_c = 1'b0;
      for (int i = 0; i < NUM_READ; i++) begin
         for (int k = DEPTH; k >= 1; k--)
            if (hit(i, k)) raw_sel[i*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(k);
         stall_c = stall_c | (id_valid & hit(i, 1) & ld[1]);
      end
   end

   assign load_use_stall = stall_c;
   assign fwd_sel        = stall_c ? '0 : raw_sel;

   always_ff @(posedge clk) begin
      if (rst) begin
         v           <= '0;
         stall_count <= '0;
      end else if (!hold) begin
         for (int k = DEPTH; k > 1; k--) begin
            v[k]   <= v[k-1] & ~(flush & (k <= FLUSH_DEPTH));
            num[k] <= num[k-1];
            ld[k]  <= ld[k-1];
         end
         // a stalled decode becomes the bubble; a flushed one is squashed
         v[1]   <= id_valid & wr_en & (wr_num != '0) & ~stall_c & ~flush;
         num[1] <= wr_num;
         ld[1]  <= wr_is_load;
         if (stall_c && stall_count != '1) stall_count <= stall_count + 32'd1;
      end
   end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: table-driven directed check of forwarding, load-use stall, flush and hold
module tb_hazard_forward_unit;
   typedef struct {
      logic       hold, flush, iv;
      logic [4:0] r1, r0;
      logic [1:0] used;
      logic [4:0] wn;
      logic       we, wl;
      logic [3:0] es, es2;
      logic       est;
      logic [31:0] ecnt;
   } vec_t;

   logic        clk = 1'b0, rst = 1'b1, hold = 1'b0, flush = 1'b0, id_valid = 1'b0;
   logic [9:0]  rd_num = '0;
   logic [1:0]  rd_used = '0;
   logic [4:0]  wr_num = '0;
   logic        wr_en = 1'b0, wr_is_load = 1'b0;
   logic [3:0]  fwd_sel, fwd_sel2;
   logic        load_use_stall, load_use_stall2;
   logic [31:0] stall_count, stall_count2;
   int          n_cmp = 0, n_bad = 0;
   vec_t        tbl[$];

   always #5 clk = ~clk;

   hazard_forward_unit dut (
      .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
      .rd_num(rd_num), .rd_used(rd_used), .wr_num(wr_num), .wr_en(wr_en),
      .wr_is_load(wr_is_load), .fwd_sel(fwd_sel), .load_use_stall(load_use_stall),
      .stall_count(stall_count)
   );

   hazard_forward_unit #(.FLUSH_DEPTH(2)) dut2 (
      .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
      .rd_num(rd_num), .rd_used(rd_used), .wr_num(wr_num), .wr_en(wr_en),
      .wr_is_load(wr_is_load), .fwd_sel(fwd_sel2), .load_use_stall(load_use_stall2),
      .stall_count(stall_count2)
   );

   function automatic vec_t mk(input logic h, f, iv, input logic [4:0] r1, r0,
                               input logic [1:0] used, input logic [4:0] wn,
                               input logic we, wl, input logic [3:0] es, es2,
                               input logic est, input logic [31:0] ecnt);
      vec_t t;
      t.hold = h; t.flush = f; t.iv = iv; t.r1 = r1; t.r0 = r0; t.used = used;
      t.wn = wn; t.we = we; t.wl = wl; t.es = es; t.es2 = es2; t.est = est; t.ecnt = ecnt;
      return t;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] act, exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      hold = t.hold; flush = t.flush; id_valid = t.iv;
      rd_num = {t.r1, t.r0}; rd_used = t.used;
      wr_num = t.wn; wr_en = t.we; wr_is_load = t.wl;
   endtask

   initial begin
      //                h  f  iv r1  r0  used  wn  we wl  es    es2   st cnt
      tbl.push_back(mk(0, 0, 1, 2,  1,  2'b11, 0,  0, 0, 4'h0, 4'h0, 0, 0)); // 0 reset view
      tbl.push_back(mk(0, 0, 1, 0,  0,  2'b00, 5,  1, 0, 4'h0, 4'h0, 0, 0)); // 1 add x5
      tbl.push_back(mk(0, 0, 1, 0,  5,  2'b01, 0,  0, 0, 4'h1, 4'h1, 0, 0)); // 2 EX fwd
      tbl.push_back(mk(0, 0, 1, 0,  5,  2'b01, 0,  0, 0, 4'h2, 4'h2, 0, 0)); // 3 MEM fwd
      tbl.push_back(mk(0, 0, 1, 0,  5,  2'b01, 0,  0, 0, 4'h0, 4'h0, 0, 0)); // 4 retired
      tbl.push_back(mk(0, 0, 1, 0,  0,  2'b00, 5,  1, 0, 4'h0, 4'h0, 0, 0)); // 5 x5
      tbl.push_back(mk(0, 0, 1, 0,  0,  2'b00, 5,  1, 0, 4'h0, 4'h0, 0, 0)); // 6 x5 again
      tbl.push_back(mk(0, 0, 1, 5,  5,  2'b11, 0,  0, 0, 4'h5, 4'h5, 0, 0)); // 7 youngest
      tbl.push_back(mk(0, 0, 1, 5,  0,  2'b10, 0,  0, 0, 4'h8, 4'h8, 0, 0)); // 8 op1 stage 2
      tbl.push_back(mk(0, 0, 1, 0,  0,  2'b00, 7,  1, 1, 4'h0, 4'h0, 0, 0)); // 9 lw x7
      tbl.push_back(mk(0, 0, 1, 0,  7,  2'b01, 8,  1, 0, 4'h0, 4'h0, 1, 0)); // 10 load-use
      tbl.push_back(mk(0, 0, 1, 8,  7,  2'b11, 0,  0, 0, 4'h2, 4'h2, 0, 1)); // 11 bubble
      tbl.push_back(mk(0, 0, 1, 0,  0,  2'b00, 9,  1, 1, 4'h0, 4'h0, 0, 1)); // 12 lw x9
      tbl.push_back(mk(0, 0, 0, 0,  9,  2'b01, 0,  0, 0, 4'h1, 4'h1, 0, 1)); // 13 no id_valid
      tbl.push_back(mk(0, 0, 1, 0,  9,  2'b01, 0,  0, 0, 4'h2, 4'h2, 0, 1)); // 14 load in MEM
      tbl.push_back(mk(0, 1, 1, 0,  0,  2'b00, 3,  1, 0, 4'h0, 4'h0, 0, 1)); // 15 flushed x3
      tbl.push_back(mk(0, 0, 1, 0,  3,  2'b01, 0,  0, 0, 4'h0, 4'h0, 0, 1)); // 16
      tbl.push_back(mk(0, 0, 1, 0,  0,  2'b00, 4,  1, 0, 4'h0, 4'h0, 0, 1)); // 17 x4
      tbl.push_back(mk(0, 1, 1, 0,  0,  2'b00, 6,  1, 0, 4'h0, 4'h0, 0, 1)); // 18 flush
      tbl.push_back(mk(0, 0, 1, 6,  4,  2'b11, 0,  0, 0, 4'h2, 4'h0, 0, 1)); // 19 depth diff
      tbl.push_back(mk(0, 0, 1, 0,  0,  2'b00, 0,  1, 0, 4'h0, 4'h0, 0, 1)); // 20 x0 writer
      tbl.push_back(mk(0, 0, 1, 0,  0,  2'b01, 0,  0, 0, 4'h0, 4'h0, 0, 1)); // 21 read x0
      tbl.push_back(mk(0, 0, 1, 0,  0,  2'b00, 10, 1, 0, 4'h0, 4'h0, 0, 1)); // 22 x10
      tbl.push_back(mk(0, 0, 1, 10, 10, 2'b10, 0,  0, 0, 4'h4, 4'h4, 0, 1)); // 23 unused op0
      tbl.push_back(mk(0, 0, 1, 0,  11, 2'b01, 11, 1, 0, 4'h0, 4'h0, 0, 1)); // 24 self read
      tbl.push_back(mk(0, 0, 1, 0,  11, 2'b01, 0,  0, 0, 4'h1, 4'h1, 0, 1)); // 25
      tbl.push_back(mk(0, 0, 1, 0,  0,  2'b00, 12, 1, 1, 4'h0, 4'h0, 0, 1)); // 26 lw x12
      tbl.push_back(mk(0, 1, 1, 0,  12, 2'b01, 13, 1, 0, 4'h0, 4'h0, 1, 1)); // 27 stall+flush
      tbl.push_back(mk(0, 0, 1, 13, 12, 2'b11, 0,  0, 0, 4'h2, 4'h0, 0, 2)); // 28
      tbl.push_back(mk(0, 0, 1, 0,  0,  2'b00, 14, 1, 0, 4'h0, 4'h0, 0, 2)); // 29 x14
      tbl.push_back(mk(1, 1, 1, 0,  14, 2'b01, 15, 1, 0, 4'h1, 4'h1, 0, 2)); // 30 hold
      tbl.push_back(mk(1, 1, 1, 0,  14, 2'b01, 15, 1, 0, 4'h1, 4'h1, 0, 2)); // 31 hold
      tbl.push_back(mk(1, 1, 1, 0,  14, 2'b01, 15, 1, 0, 4'h1, 4'h1, 0, 2)); // 32 hold
      tbl.push_back(mk(0, 0, 1, 0,  14, 2'b01, 0,  0, 0, 4'h1, 4'h1, 0, 2)); // 33 released
      tbl.push_back(mk(0, 0, 1, 0,  14, 2'b01, 0,  0, 0, 4'h2, 4'h2, 0, 2)); // 34
      tbl.push_back(mk(0, 0, 1, 0,  0,  2'b00, 16, 1, 1, 4'h0, 4'h0, 0, 2)); // 35 lw x16
      tbl.push_back(mk(1, 0, 1, 0,  16, 2'b01, 0,  0, 0, 4'h0, 4'h0, 1, 2)); // 36 held stall
      tbl.push_back(mk(1, 0, 1, 0,  16, 2'b01, 0,  0, 0, 4'h0, 4'h0, 1, 2)); // 37 held stall
      tbl.push_back(mk(0, 0, 1, 0,  16, 2'b01, 0,  0, 0, 4'h0, 4'h0, 1, 2)); // 38 counted
      tbl.push_back(mk(0, 0, 1, 0,  16, 2'b01, 0,  0, 0, 4'h2, 4'h2, 0, 3)); // 39

      repeat (2) @(negedge clk);
      rst = 1'b0;
      foreach (tbl[r]) begin
         @(negedge clk);
         drive(tbl[r]);
         #1;
         chk("fwd_sel", r, 32'(fwd_sel), 32'(tbl[r].es));
         chk("fwd_sel_fd2", r, 32'(fwd_sel2), 32'(tbl[r].es2));
         chk("load_use_stall", r, 32'(load_use_stall), 32'(tbl[r].est));
         chk("stall_count", r, stall_count, tbl[r].ecnt);
      end

      // reset must win over hold
      @(negedge clk);
      drive(mk(0, 0, 1, 0, 0, 2'b00, 17, 1, 0, 0, 0, 0, 0));
      @(negedge clk);
      drive(mk(1, 0, 1, 0, 17, 2'b01, 0, 0, 0, 0, 0, 0, 0));
      rst = 1'b1;
      #1;
      chk("pre_rst_sel", 100, 32'(fwd_sel), 32'h1);
      @(negedge clk);
      rst = 1'b0;
      drive(mk(0, 0, 1, 0, 17, 2'b01, 0, 0, 0, 0, 0, 0, 0));
      #1;
      chk("rst_hold_sel", 101, 32'(fwd_sel), 32'h0);
      chk("rst_hold_sel_fd2", 101, 32'(fwd_sel2), 32'h0);
      chk("rst_hold_cnt", 101, stall_count, 32'h0);
      chk("rst_hold_cnt_fd2", 101, stall_count2, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised data-hazard unit for the pipelined RISC-V core, sitting beside the decode stage. It tracks the destination registers of the last DEPTH issued instructions in a valid-tagged shift register. For each decode source operand it selects the youngest in-flight producer to forward from, and it raises a load-use stall when forwarding cannot cover the hazard. Squash on flush is per-entry, so no blanket forwarding blackout is needed after a flush.

Parameters:
REG_NUM_WIDTH, 5, register index width (x0 is never a hazard)
NUM_READ, 2, number of decode source operands checked
DEPTH, 2, in-flight stages tracked (stage 1 = EX, stage 2 = MEM, ...); range 1..7
FLUSH_DEPTH, 1, tracked entries squashed by flush, counting the incoming decode instruction as the first; range 1..DEPTH
SEL_WIDTH, 2, width of each forward select; must satisfy 2^SEL_WIDTH > DEPTH

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
hold  in  1  global pipeline freeze (e.g. memory wait)
flush  in  1  control-flow squash request
id_valid  in  1  decode slot holds a real instruction
rd_num  in  NUM_READ*REG_NUM_WIDTH  source register indices; operand i at [i*W +: W]
rd_used  in  NUM_READ  operand i is actually read by the instruction
wr_num  in  REG_NUM_WIDTH  destination of the decode instruction
wr_en  in  1  decode instruction writes wr_num
wr_is_load  in  1  decode instruction is a load
fwd_sel  out  NUM_READ*SEL_WIDTH  per operand: 0 = register file, k = forward from stage k
load_use_stall  out  1  hold fetch/decode and insert a bubble into EX
stall_count  out  32  saturating count of load-use stall cycles

Behaviour:
- State: entry[1..DEPTH], each {valid, num, is_load}. Outputs fwd_sel and load_use_stall are combinational from state and inputs, with zero latency.
- Match(i,k): rd_used[i] & rd_num[i]!=0 & entry[k].valid & entry[k].num==rd_num[i].
- fwd_sel[i] = smallest k with Match(i,k), i.e. the youngest producer wins. Otherwise 0.
- load_use_stall = id_valid & any i: Match(i,1) & entry[1].is_load. Loads in stage >=2 are forwarded normally.
- While load_use_stall=1, all fwd_sel fields are 0.
- Update at posedge clk, in priority order:
  - rst: all entries invalid, stall_count=0. Applies even with hold=1.
  - hold=1: no state change, and flush is ignored. Upstream keeps flush asserted until hold drops.
  - Otherwise:
    - entry[k+1] <= entry[k] for k=1..DEPTH-1; entry[DEPTH] is discarded.
    - entry[1] <= {id_valid & wr_en & (wr_num!=0) & ~load_use_stall & ~flush, wr_num, wr_is_load}.
    - If flush=1, entries that land in stages 2..FLUSH_DEPTH after the shift are written invalid.
    - stall_count increments when load_use_stall=1 and saturates at 0xFFFFFFFF.
- Reset values: all entries invalid, so fwd_sel=0, load_use_stall=0 (given no valid entries) and stall_count=0.
- Simultaneous flush and load_use_stall: flush wins. The bubble and the squash are the same invalid entry. The counter still counts the cycle if the stall was asserted.
- wr_num==rd_num within the same instruction (e.g. addi x5,x5,1) compares only against older entries, never itself.
- Fully parametric: no hardcoded stage count, and no behaviour depends on NUM_READ beyond replication.

Test Plan:
- Reset, then id_valid=1, rd_num={x2,x1}, used=11 -> fwd_sel all 0, load_use_stall=0, stall_count=0.
- Issue add x5 (wr_en=1), next cycle read x5 on operand 0 -> fwd_sel[0]=1. One cycle later, with a non-writing instruction in between, -> fwd_sel[0]=2. DEPTH=2, third cycle -> 0.
- Issue x5 writer twice back-to-back, then read x5 -> fwd_sel=1 (youngest wins, not 2).
- Issue lw x7, next decode reads x7 -> load_use_stall=1, fwd_sel=0, stall_count 0->1. Next cycle (bubble in stage 1) -> stall=0, fwd_sel=2.
- Issue addi x3, assert flush that cycle, then read x3 -> fwd_sel=0. With FLUSH_DEPTH=2, the older stage-1 writer is also squashed -> its register reads 0.
- Read x0 with a valid x0 writer, or rd_used=0 for an operand matching stage 1 -> fwd_sel=0. hold=1 for 3 cycles with flush -> entries and fwd_sel are unchanged.
